// File: rtl/rle_frame_writer.sv
// Run-length decoder for the 1-bit video stream.
// Expands colour/length tokens into packed frame-buffer words.
module rle_frame_writer #(
   parameter int DATA_WIDTH   = 16,
   parameter int ADDR_WIDTH   = 15,
   parameter int FRAME_PIXELS = 307200,
   parameter int CNT_WIDTH    = 19
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  frame_start,
   input  logic                  tok_valid,
   input  logic [15:0]           tok_data,
   output logic                  tok_ready,
   output logic                  we,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [DATA_WIDTH-1:0] wdata,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  overrun_err
);

   localparam int BPW = $clog2(DATA_WIDTH);
   localparam int NW  = (CNT_WIDTH > 16) ? CNT_WIDTH + 1 : 17;
   localparam logic [NW-1:0]        DW_N  = NW'(DATA_WIDTH);
   localparam logic [NW-1:0]        FP_N  = NW'(FRAME_PIXELS);
   localparam logic [BPW:0]         DW_E  = (BPW+1)'(DATA_WIDTH);
   localparam logic [CNT_WIDTH-1:0] FP_C  = CNT_WIDTH'(FRAME_PIXELS);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      FILL,
      DONE
   } state_t;

   state_t state, state_nx;

   logic                  colour;
   logic [15:0]           run_rem;
   logic [CNT_WIDTH-1:0]  pix_cnt;
   logic [ADDR_WIDTH-1:0] word_idx;
   logic [BPW-1:0]        bit_pos;
   logic [DATA_WIDTH-1:0] shift;

   logic [NW-1:0]         room_w;
   logic [NW-1:0]         room_f;
   logic [NW-1:0]         n;
   logic [BPW:0]          end_pos;
   logic [CNT_WIDTH-1:0]  pix_nx;
   logic [15:0]           run_nx;
   logic [DATA_WIDTH-1:0] ones;
   logic [DATA_WIDTH-1:0] mask;
   logic [DATA_WIDTH-1:0] base;
   logic [DATA_WIDTH-1:0] shift_nx;
   logic                  word_full;
   logic                  frame_end;
   logic                  run_left;

   // Pixels consumed this cycle: bounded by run, word room and frame room.
   always_comb begin
      room_w = DW_N - NW'(bit_pos);
      room_f = FP_N - NW'(pix_cnt);
      n      = NW'(run_rem);
      if (room_w < n) n = room_w;
      if (room_f < n) n = room_f;
      end_pos   = {1'b0, bit_pos} + (BPW+1)'(n);
      word_full = (end_pos == DW_E);
      pix_nx    = pix_cnt + CNT_WIDTH'(n);
      frame_end = (pix_nx == FP_C);
      run_nx    = run_rem - 16'(n);
      run_left  = (run_nx != 16'd0);
      ones      = (DATA_WIDTH'(1) << n) - DATA_WIDTH'(1);
      mask      = ones << bit_pos;
      // A fresh word starts from zero so no stale pixels leak in.
      base      = (bit_pos == '0) ? '0 : shift;
      shift_nx  = colour ? (base | mask) : (base & ~mask);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      tok_ready = 1'b0;
      unique case (state)
         IDLE: begin
            if (frame_start) state_nx = FETCH;
         end
         FETCH: begin
            tok_ready = 1'b1;
            if (tok_valid) state_nx = FILL;
         end
         FILL: begin
            if (frame_end)     state_nx = DONE;
            else if (!run_left) state_nx = FETCH;
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         colour      <= 1'b0;
         run_rem     <= '0;
         pix_cnt     <= '0;
         word_idx    <= '0;
         bit_pos     <= '0;
         shift       <= '0;
         we          <= 1'b0;
         addr        <= '0;
         wdata       <= '0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         we         <= 1'b0;
         frame_done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (frame_start) begin
                  pix_cnt     <= '0;
                  word_idx    <= '0;
                  bit_pos     <= '0;
                  shift       <= '0;
                  overrun_err <= 1'b0;
                  busy        <= 1'b1;
               end
            end
            FETCH: begin
               if (tok_valid) begin
                  colour  <= tok_data[15];
                  run_rem <= {1'b0, tok_data[14:0]} + 16'd1;
               end
            end
            FILL: begin
               run_rem <= run_nx;
               pix_cnt <= pix_nx;
               shift   <= shift_nx;
               if (word_full) begin
                  we       <= 1'b1;
                  addr     <= word_idx;
                  wdata    <= shift_nx;
                  word_idx <= word_idx + 1'b1;
                  bit_pos  <= '0;
               end else begin
                  bit_pos  <= end_pos[BPW-1:0];
               end
               // Frame end wins; leftover run length is dropped.
               if (frame_end && run_left) overrun_err <= 1'b1;
            end
            DONE: begin
               frame_done <= 1'b1;
               busy       <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
